tdm_demux_1_4: RTL and testbench

//  Receive end of the 4:1 lane-select path: a time-division demultiplexer.

---
 rtl/tdm_pkg.sv | 16 +
 rtl/tdm_slot_ctr.sv | 33 +++
 rtl/tdm_demux_1_4.sv | 117 +++++++++++
 tb/tb_tdm_demux_1_4.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the 1:4 TDM demultiplexer.
// Slot-width function, FSM state encoding and error-count ceiling.
package tdm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic int sw_of(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: inc advances, sof forces 1 (slot 0 taken now).
// Ports: clk, rst_n, inc, sof -> cnt (current slot), wrap (last slot taken).
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int LANES = 4,
  localparam int SW = sw_of(LANES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          sof,
  output logic [SW-1:0] cnt,
  output logic          wrap
);

  localparam logic [SW-1:0] LAST = SW'(LANES - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  // A qualified SOF never completes a frame.
  assign wrap = inc && !sof && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sof) begin
      cnt <= ONE;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/tdm_demux_1_4.sv
// 1:LANES time-division demux: steers stream samples into lanes, publishes frames.
// Ports: clk, rst_n, in_data/in_valid/in_sof -> sel, out_data, frame_valid,
// frame_err, err_cnt (err_cnt only when TDM_ERR_CNT_EN is defined).
module tdm_demux_1_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  localparam int SW = sw_of(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic [SW-1:0]          sel,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   frame_valid,
  output logic                   frame_err
`ifdef TDM_ERR_CNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  localparam int AW = (LANES - 1) * WIDTH;

  state_t          state_q;
  state_t          state_d;
  logic            sof_v;
  logic            early;
  logic            wrap;
  logic [SW-1:0]   wr_sel;
  logic [AW-1:0]   asm_q;

  assign sof_v = in_valid && in_sof;

  // An SOF always lands in lane 0, whatever sel says.
  assign wr_sel = sof_v ? '0 : sel;

  tdm_slot_ctr #(
    .LANES (LANES)
  ) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_valid),
    .sof   (sof_v),
    .cnt   (sel),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    early   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (sof_v) begin
          early = 1'b1;
        end else if (wrap) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Lanes 0..LANES-2 are held here; the last lane
  // comes straight from in_data at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_q <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < LANES - 1; i++) begin
        if (wr_sel == SW'(i)) begin
          asm_q[i*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= wrap;
      frame_err   <= early;
      if (wrap) begin
        out_data <= {in_data, asm_q};
      end
    end
  end

`ifdef TDM_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (early && err_cnt != ERR_CNT_MAX) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Scoreboard bench for tdm_demux_1_4: directed cases then random traffic.
// Reference model collects samples in a queue and pushes expected pulses.
module tb_tdm_demux_1_4;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_sof = 1'b0;
  logic [SW-1:0]  sel;
  logic [L*W-1:0] out_data;
  logic           frame_valid;
  logic           frame_err;
`ifdef TDM_ERR_CNT_EN
  logic [7:0]     err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_on = 0;

  logic [W-1:0]   part[$];
  logic [L*W-1:0] frame_q[$];
  bit             err_q[$];
  logic [L*W-1:0] exp_out = '0;
  int             exp_ecnt = 0;

  always #5 clk = ~clk;

  tdm_demux_1_4 #(
    .WIDTH (W),
    .LANES (L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .sel         (sel),
    .out_data    (out_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
`ifdef TDM_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is whatever LANES samples
  // accumulate since the last frame, SOF or reset.
  always @(posedge clk) begin
    logic [L*W-1:0] f;
    if (!rst_n) begin
      part.delete();
      exp_out  = '0;
      exp_ecnt = 0;
    end else if (in_valid) begin
      if (in_sof && part.size() != 0) begin
        part.delete();
        err_q.push_back(1'b1);
        if (exp_ecnt < 255) exp_ecnt++;
      end
      part.push_back(in_data);
      if (part.size() == L) begin
        f = '0;
        for (int i = 0; i < L; i++) f[i*W +: W] = part[i];
        frame_q.push_back(f);
        exp_out = f;
        part.delete();
      end
    end
  end

  always @(negedge clk) begin
    logic [L*W-1:0] ef;
    bit             eb;
    if (mon_on) begin
      check("sel", 64'(sel), 64'(part.size()));
      check("out_data", 64'(out_data), 64'(exp_out));
      check("frame_valid", 64'(frame_valid),
            64'(frame_q.size() != 0));
      if (frame_valid && frame_q.size() != 0) begin
        ef = frame_q.pop_front();
        check("frame_data", 64'(out_data), 64'(ef));
      end
      check("frame_err", 64'(frame_err),
            64'(err_q.size() != 0));
      if (frame_err && err_q.size() != 0) eb = err_q.pop_front();
`ifdef TDM_ERR_CNT_EN
      check("err_cnt", 64'(err_cnt), 64'(exp_ecnt));
`endif
    end
  end

  task automatic send(input logic [W-1:0] d, input logic s);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = $urandom_range(0, 1);
      in_data  = W'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst_n    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_on = 1;
    @(negedge clk);
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_out", 64'(out_data), 64'd0);
    check("rst_fv", 64'(frame_valid), 64'd0);
    check("rst_fe", 64'(frame_err), 64'd0);

    // 2: back-to-back frame
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    idle(1);
    @(negedge clk);
    check("t2_fv", 64'(frame_valid), 64'd1);
    check("t2_out", 64'(out_data), 64'h44332211);

    // 3: gap inside a frame
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    idle(3);
    @(negedge clk);
    check("t3_gap_sel", 64'(sel), 64'd2);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    idle(1);
    @(negedge clk);
    check("t3_out", 64'(out_data), 64'h44332211);

    // 4: early SOF abort
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    @(negedge clk);
    check("t4_err", 64'(frame_err), 64'd1);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    idle(1);
    @(negedge clk);
    check("t4_out", 64'(out_data), 64'h04030201);
`ifdef TDM_ERR_CNT_EN
    check("t4_cnt", 64'(err_cnt), 64'd1);
`endif

    // 5: reset mid-frame, then frame without SOF
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    do_reset(1);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    idle(1);
    @(negedge clk);
    check("t5_out", 64'(out_data), 64'hC4C3C2C1);

    // 6: error counter saturation
    do_reset(1);
    send(8'h00, 1'b0);
    for (int i = 0; i < 260; i++) send(W'(i), 1'b1);
    idle(1);
    @(negedge clk);
`ifdef TDM_ERR_CNT_EN
    check("t6_cnt", 64'(err_cnt), 64'hFF);
`endif
    check("t6_sel", 64'(sel), 64'd1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 2));
      end else if ($urandom_range(0, 99) < 70) begin
        send(W'($urandom), $urandom_range(0, 9) == 0);
      end else begin
        idle(1);
      end
    end
    idle(2);
    @(negedge clk);
    check("frame_q_empty", 64'(frame_q.size()), 64'd0);
    check("err_q_empty", 64'(err_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
